// File: rtl/freq_div_pkg.sv
// Shared constants and types for the programmable clock-enable divider.
//   DIV_WIDTH        default width of the half-period counter
//   CLK_HZ           nominal system clock frequency
//   DEFAULT_DIV_2KHZ half-period giving 2 kHz from CLK_HZ
//   load_state_t     encoding of the half-period load handshake FSM
package freq_div_pkg;

    localparam int DIV_WIDTH        = 16;
    localparam int CLK_HZ           = 50_000_000;
    localparam int DEFAULT_DIV_2KHZ = 12500;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } load_state_t;

endpackage

// File: rtl/div_counter.sv
// Up-counter with enable, synchronous clear and a terminal-count compare.
//   clk, rst  clock and asynchronous active-high reset
//   en        count enable; tc is only raised while enabled
//   clr       synchronous clear, wins over en and tc
//   term      terminal value (full-width equality compare)
//   cnt       current count
//   tc        terminal count reached this cycle; cnt wraps to 0 on the next edge
module div_counter
    import freq_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    assign tc = en & ~clr & (cnt == term);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/prog_freq_div.sv
// Runtime-programmable 50%-duty clock-enable generator.
//   clk, rst   system clock, asynchronous active-high reset
//   en         1 = run, 0 = freeze counter and output
//   sync_clr   synchronous phase restart (cnt=0, clk_div=0)
//   div_val    requested half-period in clk cycles (0 treated as 1)
//   load       one-cycle request to adopt div_val
//   load_ack   one-cycle pulse when the new half-period becomes active
//   busy       a load is pending and not yet applied
//   clk_div    divided square wave, period 2*hp
//   tick       pulse on every clk_div toggle
//   rise_tick  pulse coincident with clk_div 0->1
//   fall_tick  pulse coincident with clk_div 1->0
//
// A new half-period only takes effect at a terminal count (so the running
// half-period always finishes with the old value), when frozen, or on sync_clr.
module prog_freq_div
    import freq_div_pkg::*;
#(
    parameter int WIDTH       = DIV_WIDTH,
    parameter int DEFAULT_DIV = DEFAULT_DIV_2KHZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [WIDTH-1:0] div_val,
    input  logic             load,
    output logic             load_ack,
    output logic             busy,
    output logic             clk_div,
    output logic             tick,
    output logic             rise_tick,
    output logic             fall_tick
);

    load_state_t      state_q, state_d;
    logic [WIDTH-1:0] hp;
    logic [WIDTH-1:0] pend_val;
    logic [WIDTH-1:0] div_clamped;
    logic [WIDTH-1:0] cnt;
    logic             tc;
    logic             apply;
    logic             capture;

    // hp is never 0, so hp-1 cannot underflow
    div_counter #(.WIDTH(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (sync_clr),
        .term (hp - WIDTH'(1)),
        .cnt  (cnt),
        .tc   (tc)
    );

    assign div_clamped = (div_val == '0) ? WIDTH'(1) : div_val;
    assign busy        = (state_q == PEND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A load arriving together with an apply stays pending for the next boundary
    always_comb begin
        state_d = state_q;
        apply   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (tc || !en || sync_clr) begin
                    apply   = 1'b1;
                    state_d = load ? PEND : IDLE;
                end
                if (load) begin
                    capture = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hp        <= WIDTH'(DEFAULT_DIV);
            pend_val  <= '0;
            load_ack  <= 1'b0;
            clk_div   <= 1'b0;
            tick      <= 1'b0;
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            if (capture) begin
                pend_val <= div_clamped;
            end
            if (apply) begin
                hp <= pend_val;
            end
            load_ack  <= apply;
            tick      <= tc;
            rise_tick <= tc & ~clk_div;
            fall_tick <= tc & clk_div;
            if (sync_clr) begin
                clk_div <= 1'b0;
            end else if (tc) begin
                clk_div <= ~clk_div;
            end
        end
    end

endmodule

// File: tb/tb_prog_freq_div.sv
module tb_prog_freq_div;

    logic        clk;
    logic        rst;
    logic        en;
    logic        sync_clr;
    logic [15:0] div_val;
    logic        load;
    logic        load_ack;
    logic        busy;
    logic        clk_div;
    logic        tick;
    logic        rise_tick;
    logic        fall_tick;

    logic        rst2;
    logic        load_ack2, busy2, clk_div2, tick2, rise2, fall2;

    int checks = 0;
    int errors = 0;

    int cyc2 = 0;
    int rise2_cnt = 0;
    int fall2_cnt = 0;
    int rise2_first = 0;
    int rise2_second = 0;
    int fall2_first = 0;

    prog_freq_div #(.WIDTH(16), .DEFAULT_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sync_clr  (sync_clr),
        .div_val   (div_val),
        .load      (load),
        .load_ack  (load_ack),
        .busy      (busy),
        .clk_div   (clk_div),
        .tick      (tick),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Default parameters: 50 MHz -> 2 kHz
    prog_freq_div dut2 (
        .clk       (clk),
        .rst       (rst2),
        .en        (1'b1),
        .sync_clr  (1'b0),
        .div_val   (16'd0),
        .load      (1'b0),
        .load_ack  (load_ack2),
        .busy      (busy2),
        .clk_div   (clk_div2),
        .tick      (tick2),
        .rise_tick (rise2),
        .fall_tick (fall2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst2 = 1'b1;
        @(negedge clk);
        #1 rst2 = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst2) begin
            cyc2++;
            if (rise2) begin
                rise2_cnt++;
                if (rise2_cnt == 1) rise2_first = cyc2;
                if (rise2_cnt == 2) rise2_second = cyc2;
            end
            if (fall2) begin
                fall2_cnt++;
                if (fall2_cnt == 1) fall2_first = cyc2;
            end
        end
    end

    initial begin
        int waited;
        rst      = 1'b1;
        en       = 1'b0;
        sync_clr = 1'b0;
        div_val  = '0;
        load     = 1'b0;
        step(3);
        check("rst_clk_div", clk_div, 0);
        check("rst_busy", busy, 0);
        check("rst_tick", tick, 0);
        check("rst_ack", load_ack, 0);
        check("rst_cnt", dut.cnt, 0);

        // default half-period 4
        rst = 1'b0;
        en  = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step(1);
            check("t1_tick", tick, (i % 4) == 0);
            check("t1_rise", rise_tick, (i % 8) == 4);
            check("t1_fall", fall_tick, (i % 8) == 0);
            check("t1_clk_div", clk_div, (i % 8) >= 4);
        end

        // load 10 at cnt=1: current half finishes with 4
        step(1);
        check("t3_cnt", dut.cnt, 1);
        load = 1'b1; div_val = 16'd10;
        step(1);
        load = 1'b0;
        check("t3_busy", busy, 1);
        step(1);
        check("t3_busy_hold", busy, 1);
        check("t3_no_tick", tick, 0);
        step(1);
        check("t3_tick", tick, 1);
        check("t3_rise", rise_tick, 1);
        check("t3_ack", load_ack, 1);
        check("t3_busy_clr", busy, 0);
        for (int j = 1; j <= 10; j++) begin
            step(1);
            check("t3_hp10_tick", tick, j == 10);
            check("t3_hp10_ack", load_ack, 0);
        end

        // loads 6 then 9 back to back: only 9 applied, single ack
        load = 1'b1; div_val = 16'd6;
        step(1);
        div_val = 16'd9;
        step(1);
        load = 1'b0;
        check("t4_busy", busy, 1);
        for (int j = 3; j <= 10; j++) begin
            step(1);
            check("t4_ack", load_ack, j == 10);
            check("t4_tick", tick, j == 10);
        end
        for (int j = 1; j <= 9; j++) begin
            step(1);
            check("t4_hp9_tick", tick, j == 9);
            check("t4_hp9_ack", load_ack, 0);
        end
        check("t4_clk_div", clk_div, 0);

        // div_val 0 clamps to 1
        load = 1'b1; div_val = 16'd0;
        step(1);
        load = 1'b0;
        waited = 0;
        while (!load_ack && waited < 20) begin
            step(1);
            waited++;
        end
        check("t5_ack_seen", load_ack, 1);
        check("t5_rise", rise_tick, 1);
        check("t5_clk_div", clk_div, 1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check("t5_tick_hi", tick, 1);
            check("t5_toggle", clk_div, (k % 2) == 0);
        end

        // sync_clr together with load from IDLE: capture, no apply yet
        load = 1'b1; div_val = 16'd5; sync_clr = 1'b1;
        step(1);
        load = 1'b0; sync_clr = 1'b0;
        check("t6_clr_clk_div", clk_div, 0);
        check("t6_clr_tick", tick, 0);
        check("t6_clr_busy", busy, 1);
        step(1);
        check("t6_apply_ack", load_ack, 1);
        check("t6_apply_rise", rise_tick, 1);
        check("t6_apply_busy", busy, 0);
        step(2);
        check("t6_cnt2", dut.cnt, 2);

        // freeze
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("t6_frz_cnt", dut.cnt, 2);
            check("t6_frz_clk_div", clk_div, 1);
            check("t6_frz_tick", tick | rise_tick | fall_tick, 0);
        end
        en = 1'b1;
        step(1);
        check("t6_resume_cnt", dut.cnt, 3);
        sync_clr = 1'b1;
        step(1);
        sync_clr = 1'b0;
        check("t6_sclr_cnt", dut.cnt, 0);
        check("t6_sclr_clk_div", clk_div, 0);
        check("t6_sclr_tick", tick, 0);
        step(5);
        check("t6_hp5_rise", rise_tick, 1);
        check("t6_hp5_clk_div", clk_div, 1);

        // async reset with a load pending
        step(2);
        load = 1'b1; div_val = 16'd7;
        step(1);
        load = 1'b0;
        check("t6_pend_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("t6_arst_clk_div", clk_div, 0);
        check("t6_arst_busy", busy, 0);
        check("t6_arst_cnt", dut.cnt, 0);
        for (int k = 0; k < 3; k++) begin
            step(1);
            check("t6_rst_ack", load_ack, 0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            check("t6_post_ack", load_ack, 0);
            check("t6_post_busy", busy, 0);
            check("t6_post_tick", tick, (i % 4) == 0);
        end

        // default-parameter instance: 2 kHz from 50 MHz
        waited = 0;
        while (cyc2 < 50010 && waited < 60000) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("t2_reached", cyc2 >= 50010, 1);
        check("t2_rise_cnt", rise2_cnt, 2);
        check("t2_fall_cnt", fall2_cnt, 2);
        check("t2_first_rise", rise2_first, 12500);
        check("t2_first_fall", fall2_first, 25000);
        check("t2_period", rise2_second - rise2_first, 25000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
